// File: rtl/char_line_fetcher.sv
// Fetches one text line of glyph slices per line_start into a ping-pong buffer
// (text RAM -> glyph ROM -> buffer) and shifts the previously filled buffer out as pixels.
module char_line_fetcher #(
  parameter int COLS   = 80,
  parameter int TXT_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start_i,
  input  logic [TXT_AW-1:0] line_base_i,
  input  logic [2:0]        glyph_row_i,
  output logic              txt_rd_o,
  output logic [TXT_AW-1:0] txt_addr_o,
  input  logic [7:0]        txt_data_i,
  output logic              rom_ce_o,
  output logic [10:0]       rom_ad_o,
  input  logic [4:0]        rom_dout_i,
  input  logic              pix_en_i,
  output logic              pix_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(COLS + 2);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CNT_W-1:0] CNT_COLS = CNT_W'(COLS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COLS + 1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS);

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TXT_AW-1:0] base_q, base_d;
  logic [2:0]        row_q, row_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              disp_valid_q, disp_valid_d;
  logic              overrun_q, overrun_d;

  logic [2:0]        bit_q, bit_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              pix_q, pix_d;

  logic [4:0]        line_buf_q [2][COLS];

  logic              fetching;
  logic              gap_row;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [4:0]        wr_data;
  logic [10:0]       code_x8;
  logic [4:0]        disp_slice;
  logic [4:0]        disp_shift;

  // ---------------------------------------------------------------------------
  // Fetch pipeline: cnt_q is the cycle index k since fetch start; column k is
  // read from text RAM at k, looked up in the ROM at k+1 and written at k+2.
  // ---------------------------------------------------------------------------
  assign fetching = (state_q == S_FETCH);
  assign gap_row  = (row_q == 3'd7);

  assign txt_rd_o   = fetching && !gap_row && (cnt_q < CNT_COLS);
  assign rom_ce_o   = fetching && !gap_row && (cnt_q != '0) && (cnt_q <= CNT_COLS);
  assign txt_addr_o = txt_rd_o ? (base_q + TXT_AW'(cnt_q)) : '0;

  // code*7 as code*8 - code; the maximum 255*7+6 fits in 11 bits.
  assign code_x8  = {txt_data_i, 3'b000};
  assign rom_ad_o = rom_ce_o ? (code_x8 - {3'b000, txt_data_i} + {8'd0, row_q}) : '0;

  assign wr_idx  = IDX_W'(cnt_q - CNT_TWO);
  assign wr_data = gap_row ? 5'd0 : rom_dout_i;

  assign busy_o    = fetching;
  assign overrun_o = overrun_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    row_d        = row_q;
    sel_d        = sel_q;
    done_d       = done_q;
    disp_valid_d = disp_valid_q;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;

    if (line_start_i) begin
      // Swap: the buffer being filled becomes the display buffer; an aborted
      // fill is shown as invalid and its in-flight data never lands.
      overrun_d    = overrun_q | fetching;
      disp_valid_d = done_q;
      done_d       = 1'b0;
      sel_d        = ~sel_q;
      base_d       = line_base_i;
      row_d        = glyph_row_i;
      cnt_d        = '0;
      state_d      = S_FETCH;
    end else if (fetching) begin
      wr_en = (cnt_q >= CNT_TWO);
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display side: bit_q walks 0..5 (5 = blank gap), col_q saturates at COLS.
  // ---------------------------------------------------------------------------
  assign disp_slice = line_buf_q[~sel_q][IDX_W'(col_q)];
  assign disp_shift = disp_slice << bit_q;
  assign pix_o      = pix_q;

  always_comb begin
    bit_d = bit_q;
    col_d = col_q;
    pix_d = pix_q;

    if (line_start_i) begin
      bit_d = '0;
      col_d = '0;
      pix_d = 1'b0;
    end else if (pix_en_i) begin
      if (col_q < COL_MAX) begin
        // Shifting by 5 empties the slice, which yields the gap pixel for free.
        pix_d = disp_valid_q & disp_shift[4];
        if (bit_q == 3'd5) begin
          bit_d = '0;
          col_d = col_q + COL_W'(1);
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end else begin
        pix_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      row_q        <= '0;
      sel_q        <= 1'b0;
      done_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      bit_q        <= '0;
      col_q        <= '0;
      pix_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      row_q        <= row_d;
      sel_q        <= sel_d;
      done_q       <= done_d;
      disp_valid_q <= disp_valid_d;
      overrun_q    <= overrun_d;
      bit_q        <= bit_d;
      col_q        <= col_d;
      pix_q        <= pix_d;
    end
  end

  // NOTE: the line buffers are not reset; the valid bit guards any stale content.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf_q[sel_q][wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_char_line_fetcher.sv
// Self-checking bench for char_line_fetcher: behavioural text RAM / glyph ROM,
// a line-level reference model, directed corner cases and a random phase.
module tb_char_line_fetcher;

  localparam int COLS = 80;
  localparam int AW   = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          line_start;
  logic [AW-1:0] line_base;
  logic [2:0]    glyph_row;
  logic          txt_rd;
  logic [AW-1:0] txt_addr;
  logic [7:0]    txt_data;
  logic          rom_ce;
  logic [10:0]   rom_ad;
  logic [4:0]    rom_dout;
  logic          pix_en;
  logic          pix;
  logic          busy;
  logic          overrun;

  char_line_fetcher #(.COLS(COLS), .TXT_AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .line_start_i (line_start),
    .line_base_i  (line_base),
    .glyph_row_i  (glyph_row),
    .txt_rd_o     (txt_rd),
    .txt_addr_o   (txt_addr),
    .txt_data_i   (txt_data),
    .rom_ce_o     (rom_ce),
    .rom_ad_o     (rom_ad),
    .rom_dout_i   (rom_dout),
    .pix_en_i     (pix_en),
    .pix_o        (pix),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  // Memories with registered read data, one cycle latency.
  logic [7:0] ram [4096];
  logic [4:0] rom [2048];

  always @(posedge clk) begin
    if (txt_rd) txt_data <= ram[txt_addr];
    if (rom_ce) rom_dout <= rom[rom_ad];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_fetching;
  int m_age;
  int m_base;
  int m_row;
  int m_fill [COLS];
  int m_disp [COLS];
  bit m_valid;
  int m_p;
  bit m_pix;
  bit m_ovr;

  int busy_seen;
  int strobe_seen;
  bit pix_or;

  function automatic int glyph(input int base, input int row, input int k);
    int code;
    if (row == 7) return 0;
    code = int'(ram[(base + k) % 4096]);
    return int'(rom[code * 7 + row]);
  endfunction

  function automatic bit exp_pixel(input int p);
    int col;
    int b;
    col = p / 6;
    b   = p % 6;
    if (b == 5) return 1'b0;
    return ((m_disp[col] >> (4 - b)) & 1) != 0;
  endfunction

  task automatic check_outputs();
    bit e_busy;
    bit e_rd;
    bit e_ce;
    e_busy = m_fetching && (m_age < COLS + 2);
    e_rd   = e_busy && (m_row != 7) && (m_age < COLS);
    e_ce   = e_busy && (m_row != 7) && (m_age >= 1) && (m_age <= COLS);
    check("busy_rd_ce_ovr", {28'd0, busy, txt_rd, rom_ce, overrun}, {28'd0, e_busy, e_rd, e_ce, m_ovr});
    if (e_rd) check("txt_addr", txt_addr, (m_base + m_age) % 4096);
    if (e_ce) check("rom_ad", rom_ad, ram[(m_base + m_age - 1) % 4096] * 7 + m_row);
    check("pix", pix, m_pix);
    if (busy) busy_seen++;
    if (txt_rd || rom_ce) strobe_seen++;
    pix_or = pix_or | pix;
  endtask

  task automatic step(input bit ls, input int base, input int row, input bit pe);
    check_outputs();
    line_start = ls;
    line_base  = base[AW-1:0];
    glyph_row  = row[2:0];
    pix_en     = pe;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    pix_en     = 1'b0;
    if (ls) begin
      if (m_fetching && m_age < COLS + 2) m_ovr = 1'b1;
      m_valid    = m_fetching && (m_age >= COLS + 2);
      m_disp     = m_fill;
      m_p        = 0;
      m_pix      = 1'b0;
      m_fetching = 1'b1;
      m_age      = 0;
      m_base     = base % 4096;
      m_row      = row;
      for (int k = 0; k < COLS; k++) m_fill[k] = glyph(m_base, m_row, k);
    end else begin
      if (m_fetching && m_age < 1000) m_age++;
      if (pe) begin
        if (m_p < COLS * 6) begin
          m_pix = m_valid && exp_pixel(m_p);
          m_p++;
        end else begin
          m_pix = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input int n, input bit pe);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, pe);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    line_start = 1'b0;
    pix_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset      = 1'b0;
    m_fetching = 1'b0;
    m_age      = 0;
    m_valid    = 1'b0;
    m_p        = 0;
    m_pix      = 1'b0;
    m_ovr      = 1'b0;
    m_row      = 0;
    m_base     = 0;
  endtask

  typedef struct {
    logic [7:0]  code;
    logic [2:0]  row;
    logic [10:0] exp_ad;
  } rom_vec_t;

  rom_vec_t vecs [5];
  logic [11:0] exp12;

  initial begin
    vecs[0] = '{code: 8'h41, row: 3'd3, exp_ad: 11'd458};
    vecs[1] = '{code: 8'hFF, row: 3'd6, exp_ad: 11'd1791};
    vecs[2] = '{code: 8'h00, row: 3'd0, exp_ad: 11'd0};
    vecs[3] = '{code: 8'h12, row: 3'd5, exp_ad: 11'd131};
    vecs[4] = '{code: 8'h80, row: 3'd2, exp_ad: 11'd898};

    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom[i] = 5'($urandom);
    txt_data  = 8'd0;
    rom_dout  = 5'd0;
    line_base = '0;
    glyph_row = 3'd0;
    for (int k = 0; k < COLS; k++) m_fill[k] = 0;

    // 1. Reset state, then pix_en with no line_start.
    do_reset();
    check("rst_pix", pix, 0);
    check("rst_busy", busy, 0);
    check("rst_txt_rd", txt_rd, 0);
    check("rst_rom_ce", rom_ce, 0);
    check("rst_overrun", overrun, 0);
    pix_or = 1'b0;
    run(1000, 1'b1);
    check("idle_pix_or", pix_or, 0);

    // 2. Uniform code 0x41 at 0x010..0x05F, row 3.
    for (int i = 'h10; i < 'h60; i++) ram[i] = 8'h41;
    busy_seen = 0;
    step(1'b1, 'h10, 3, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    check("rom_ad_458", rom_ad, 458);
    run(COLS + 6, 1'b0);
    check("busy_cycles", busy_seen, COLS + 2);

    // 3. ROM address arithmetic table.
    for (int v = 0; v < 5; v++) begin
      ram['h300] = vecs[v].code;
      step(1'b1, 'h300, int'(vecs[v].row), 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check("rom_ad_vec", rom_ad, vecs[v].exp_ad);
      run(COLS + 2, 1'b0);
    end

    // 4. Known slices in col0/col1, then shift out.
    ram['h400] = 8'h20;
    ram['h401] = 8'h21;
    rom['h20 * 7 + 2] = 5'b10110;
    rom['h21 * 7 + 2] = 5'b01101;
    step(1'b1, 'h400, 2, 1'b0);
    run(COLS + 4, 1'b0);
    step(1'b1, 'h500, 0, 1'b0);
    exp12 = 12'b101100_011010;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 0, 0, 1'b1);
      check("pix_col01", pix, exp12[11-i]);
    end
    run(468, 1'b1);
    check("pix_line_end", pix, 0);
    run(20, 1'b1);
    check("pix_saturated", pix, 0);

    // Swap and pix_en in the same cycle: swap wins, pix forced 0.
    step(1'b1, 'h10, 3, 1'b1);
    check("ls_pe_pix", pix, 0);
    run(COLS + 4, 1'b0);

    // 5. Gap row: no strobes, normal busy, blank displayed line.
    busy_seen   = 0;
    strobe_seen = 0;
    step(1'b1, 'h600, 7, 1'b0);
    run(COLS + 4, 1'b0);
    check("gap_busy_cycles", busy_seen, COLS + 2);
    check("gap_strobes", strobe_seen, 0);
    step(1'b1, 'h10, 3, 1'b0);
    pix_or = 1'b0;
    run(480, 1'b1);
    check("gap_line_pix_or", pix_or, 0);

    // 6. Overrun: second line_start 10 cycles into a fetch.
    run(COLS + 4, 1'b0);
    step(1'b1, 'h700, 1, 1'b0);
    run(10, 1'b0);
    check("no_overrun_yet", overrun, 0);
    step(1'b1, 'h020, 4, 1'b0);
    check("overrun_set", overrun, 1);
    check("restart_addr", txt_addr, 'h020);
    pix_or = 1'b0;
    run(480, 1'b1);
    check("aborted_line_pix_or", pix_or, 0);
    step(1'b1, 'h030, 2, 1'b0);
    run(COLS + 4, 1'b1);
    check("overrun_sticky", overrun, 1);
    do_reset();
    check("overrun_cleared", overrun, 0);

    // 7. Random traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 149) == 0, int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 7)), 1'($urandom));
    end
    do_reset();
    check("final_reset_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
